// File: rtl/uart_packet_tx_if.sv
// Request channel of the UART packet transmitter: payload, length and valid/ready handshake.
interface uart_packet_tx_if #(
  parameter int unsigned PACKET_SIZE = 2
);
  localparam int unsigned LW = $clog2(PACKET_SIZE + 1);

  logic [8*PACKET_SIZE-1:0] packet;
  logic [LW-1:0]            len;
  logic                     valid;
  logic                     ready;

  modport master (output packet, len, valid, input ready);
  modport slave  (input packet, len, valid, output ready);
endinterface

// File: rtl/uart_packet_tx.sv
// Multi-byte UART transmitter: sends up to PACKET_SIZE bytes as 8N1/8N2 frames per accepted request.
module uart_packet_tx #(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned PACKET_SIZE = 2,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic              hwclk,
  input  logic              rst_n,
  uart_packet_tx_if.slave   bus,
  output logic              txd,
  output logic              busy,
  output logic              done
);
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned LW = $clog2(PACKET_SIZE + 1);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int unsigned PW = 8 * PACKET_SIZE;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic          txd_d, busy_d, done_d;

  logic [LW-1:0] len_eff;
  logic [IW-1:0] sel;
  logic [7:0]    cur_byte;
  logic          bit_end;

  assign bus.ready = (state_q == IDLE);

  // Requested length clamped to the payload capacity
  assign len_eff = (32'(bus.len) > PACKET_SIZE) ? LW'(PACKET_SIZE) : bus.len;

  // Byte on the line: index counts in transmission order, mapped onto the payload per byte order
  assign sel      = (MSB_FIRST != 0) ? (IW'(PACKET_SIZE - 1) - idx_q) : idx_q;
  assign cur_byte = 8'(pkt_q >> {sel, 3'b000});
  assign bit_end  = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pkt_d   = pkt_q;
    txd_d   = txd;
    busy_d  = busy;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (bus.valid) begin
          pkt_d  = bus.packet;
          len_d  = len_eff;
          baud_d = '0;
          bit_d  = '0;
          idx_d  = '0;
          if (len_eff != '0) begin
            state_d = START;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          txd_d   = cur_byte[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = cur_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP: begin
        // bit_q counts stop bits here; the last one either chains the next byte or closes the packet
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            if ((LW'(idx_q) + LW'(1)) < len_q) begin
              idx_d   = idx_q + IW'(1);
              state_d = START;
              txd_d   = 1'b0;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pkt_q   <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pkt_q   <= pkt_d;
      txd     <= txd_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: two configurations (MSB-first/1 stop, LSB-first/2 stop) against a waveform model.
module tb_uart_packet_tx;
  localparam int unsigned CPB = 4;
  localparam int unsigned PS  = 2;

  logic hwclk;
  logic rst_n;
  logic txd_a, busy_a, done_a;
  logic txd_b, busy_b, done_b;
  logic sel;
  int   total;
  int   bad;
  bit   exp_q[$];

  uart_packet_tx_if #(.PACKET_SIZE(PS)) ifa ();
  uart_packet_tx_if #(.PACKET_SIZE(PS)) ifb ();

  uart_packet_tx #(.CLK_HZ(12000000), .BAUD(3000000), .PACKET_SIZE(PS),
                   .STOP_BITS(1), .MSB_FIRST(1)) u_a (
    .hwclk(hwclk), .rst_n(rst_n), .bus(ifa), .txd(txd_a), .busy(busy_a), .done(done_a));

  uart_packet_tx #(.CLK_HZ(12000000), .BAUD(3000000), .PACKET_SIZE(PS),
                   .STOP_BITS(2), .MSB_FIRST(0)) u_b (
    .hwclk(hwclk), .rst_n(rst_n), .bus(ifb), .txd(txd_b), .busy(busy_b), .done(done_b));

  wire txd_m   = sel ? txd_b : txd_a;
  wire busy_m  = sel ? busy_b : busy_a;
  wire done_m  = sel ? done_b : done_a;
  wire ready_m = sel ? ifb.ready : ifa.ready;

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [15:0] p, input logic [1:0] l);
    if (s) begin
      ifb.valid = v; ifb.packet = p; ifb.len = l;
    end else begin
      ifa.valid = v; ifa.packet = p; ifa.len = l;
    end
  endtask

  // Expected txd waveform, one entry per clock, from the framing rules
  task automatic build(input bit msb, input int stops, input logic [15:0] p, input int l);
    int n;
    int bi;
    logic [7:0] by;
    exp_q.delete();
    n = (l > int'(PS)) ? int'(PS) : l;
    for (int b = 0; b < n; b++) begin
      bi = msb ? (int'(PS) - 1 - b) : b;
      by = p[8*bi +: 8];
      repeat (CPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(by[i]);
      repeat (stops * CPB) exp_q.push_back(1'b1);
    end
  endtask

  // Starts and ends at a falling edge; ends in the done cycle
  task automatic run_packet(input logic s, input logic [15:0] p, input int l,
                            input bit hold, input bit glitch);
    sel = s;
    build(!s, s ? 2 : 1, p, l);
    drive(s, 1'b1, p, 2'(l));
    @(negedge hwclk);
    if (!hold) drive(s, 1'b0, 16'($urandom), 2'($urandom));
    for (int k = 0; k < exp_q.size(); k++) begin
      chk("txd_bit", txd_m, exp_q[k]);
      chk("busy_mid", busy_m, 1'b1);
      chk("ready_mid", ready_m, 1'b0);
      chk("done_mid", done_m, 1'b0);
      if (glitch && k == 20) drive(s, 1'b1, ~p, 2'd2);
      if (glitch && k == 21) drive(s, 1'b0, ~p, 2'd2);
      @(negedge hwclk);
    end
    chk("done_end", done_m, 1'b1);
    chk("busy_end", busy_m, 1'b0);
    chk("ready_end", ready_m, 1'b1);
    chk("txd_end", txd_m, 1'b1);
  endtask

  task automatic idle_check(input logic s, input int n);
    sel = s;
    repeat (n) begin
      @(negedge hwclk);
      chk("idle_txd", txd_m, 1'b1);
      chk("idle_busy", busy_m, 1'b0);
      chk("idle_done", done_m, 1'b0);
      chk("idle_ready", ready_m, 1'b1);
    end
  endtask

  initial begin
    logic [15:0] rp;
    logic        rs;
    int          rl;
    total = 0;
    bad   = 0;
    sel   = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 2'd0);
    drive(1'b1, 1'b0, 16'h0, 2'd0);
    repeat (3) @(negedge hwclk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("rst_txd", txd_m, 1'b1);
      chk("rst_busy", busy_m, 1'b0);
      chk("rst_done", done_m, 1'b0);
      chk("rst_ready", ready_m, 1'b1);
    end
    rst_n = 1'b1;
    @(negedge hwclk);

    // "ab", MSB first, two bytes, 80 cycles
    run_packet(1'b0, 16'h6162, 2, 1'b0, 1'b0);
    idle_check(1'b0, 3);

    // LSB first: len=1 sends only 0x62, len=3 clamps to two bytes
    run_packet(1'b1, 16'h6162, 1, 1'b0, 1'b0);
    idle_check(1'b1, 3);
    run_packet(1'b1, 16'h6162, 3, 1'b0, 1'b0);
    idle_check(1'b1, 3);

    // Zero length: immediate done, no transmission
    run_packet(1'b0, 16'h1234, 0, 1'b0, 1'b0);
    idle_check(1'b0, 4);

    // Back-to-back with valid held, two stop bits
    run_packet(1'b1, 16'h00C3, 1, 1'b1, 1'b0);
    run_packet(1'b1, 16'h00C3, 1, 1'b1, 1'b0);
    run_packet(1'b1, 16'h00C3, 1, 1'b0, 1'b0);
    idle_check(1'b1, 3);

    // Request while busy is ignored and leaves no trailing frame
    run_packet(1'b0, 16'hA55A, 2, 1'b0, 1'b1);
    idle_check(1'b0, 50);

    // Reset during data bit 3 of the first byte
    sel = 1'b0;
    build(1'b1, 1, 16'h3C96, 2);
    drive(1'b0, 1'b1, 16'h3C96, 2'd2);
    @(negedge hwclk);
    drive(1'b0, 1'b0, 16'h0, 2'd0);
    for (int k = 0; k < 18; k++) begin
      chk("pre_rst_txd", txd_m, exp_q[k]);
      @(negedge hwclk);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_txd", txd_m, 1'b1);
    chk("arst_busy", busy_m, 1'b0);
    chk("arst_done", done_m, 1'b0);
    chk("arst_ready", ready_m, 1'b1);
    @(negedge hwclk);
    rst_n = 1'b1;
    idle_check(1'b0, 2);
    run_packet(1'b0, 16'h7E81, 2, 1'b0, 1'b0);
    idle_check(1'b0, 2);

    // Random packets, lengths 0..3, on either configuration
    for (int i = 0; i < 10; i++) begin
      rs = 1'($urandom);
      rp = 16'($urandom);
      rl = int'($urandom_range(0, 3));
      run_packet(rs, rp, rl, 1'b0, 1'b0);
      idle_check(rs, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
